redmule_job_dispatcher: RTL and testbench
=========================================

Name: redmule_job_dispatcher

Overview:
- Bus initiator that drives the HWPE peripheral control port of a RedMulE instance.
- Accepts a job descriptor (register-file image) through a valid/ready handshake. Acquires an accelerator context, programs every job register, triggers the job, then waits for the completion event.
- Sits in the cluster-side test/offload infrastructure, directly facing the accelerator's control slave.

Parameters:
- BaseAddr, 32'h0000_0000, byte base address of the accelerator control slave.
- NumRegs, 12, number of 32-bit job registers written per job.
- IdWidth, 8, width of periph transaction ID and returned job ID.
- BackoffCycles, 4, idle cycles between a failed acquire and the retry.
- TimeoutCycles, 65536, event watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- job_valid_i  in  1  descriptor valid
- job_ready_o  out  1  descriptor accepted when valid&ready
- job_regs_i  in  NumRegs*32  descriptor, word i goes to register i
- job_done_o  out  1  one-cycle pulse on job completion
- job_id_o  out  IdWidth  ID of the last acquired context; valid while job_done_o=1
- busy_o  out  1  high in every state except IDLE
- timeout_o  out  1  one-cycle pulse on watchdog expiry (tied 0 without the feature)
- periph_req_o  out  1  request
- periph_gnt_i  in  1  grant
- periph_add_o  out  32  byte address
- periph_wen_o  out  1  1=read, 0=write
- periph_be_o  out  4  byte enable, always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  IdWidth  transaction ID, constant 0
- periph_r_valid_i  in  1  read response valid
- periph_r_data_i  in  32  read response data
- periph_r_id_i  in  IdWidth  read response ID
- evt_i  in  1  accelerator completion event (the core's bit 0)

Behaviour:
- Reset: state IDLE; all outputs 0 except periph_be_o=4'hF. Latched descriptor, counters and job_id_o are cleared.
- Request rule: once periph_req_o rises, add/wen/data stay stable until the cycle periph_gnt_i=1. A transaction completes on gnt for writes, or on r_valid with r_id==0 for reads. Responses with any other ID are ignored.
- FSM:
  - IDLE: job_ready_o=1. On valid&ready, latch job_regs_i and go to ACQ.
  - ACQ: read at BaseAddr+0x04. On gnt go to ACQ_RSP.
  - ACQ_RSP: wait for the response.
    - If r_data[31]=1 (no free context), go to BACKOFF.
    - Otherwise set job_id_o<=r_data[IdWidth-1:0] and go to PROG with index 0.
  - BACKOFF: count BackoffCycles cycles, then go to ACQ. There is no retry limit.
  - PROG: write job_regs[idx] to BaseAddr+0x40+4*idx.
    - On gnt, increment idx.
    - Gnt on idx==NumRegs-1 goes to TRIG, so exactly NumRegs writes are issued.
  - TRIG: write 32'h0 to BaseAddr+0x00. On gnt go to WAIT_EVT.
  - WAIT_EVT: on evt_i=1 go to DONE. evt_i is ignored in every other state.
  - DONE: job_done_o=1 for one cycle, then go to IDLE.
- Back-to-back jobs: after DONE, job_ready_o rises the following cycle. No descriptor is accepted while busy.
- Throughput: with gnt=1 every cycle, PROG takes NumRegs cycles. Latency from acceptance to the trigger grant is 2+r_latency+NumRegs+1 cycles.
- idx is $clog2(NumRegs) bits wide and never wraps past NumRegs-1.
- clear_i:
  - In IDLE, BACKOFF, WAIT_EVT or DONE: return to IDLE next cycle with no done pulse.
  - In ACQ, PROG or TRIG: clear is latched and taken once the in-flight request is granted.
  - In ACQ_RSP: clear is latched and taken once the response is received.
  - An abandoned context is not released by hardware.
- Simultaneous clear_i and job_valid_i in IDLE: clear wins and the descriptor is not accepted.
- Asynchronous reset mid-transaction drops req immediately. Bus-side recovery is the system's responsibility.

Optional Feature:
- Macro: REDMULE_DISPATCH_TIMEOUT_EN.
- Enabled:
  - A $clog2(TimeoutCycles+1)-bit counter runs in WAIT_EVT and resets on entry.
  - When it reaches TimeoutCycles without evt_i, the block pulses timeout_o and writes 32'h0 to BaseAddr+0x14 (SOFT_CLEAR).
  - On gnt of that write it returns to IDLE, with no job_done_o.
  - evt_i arriving in the same cycle as expiry wins and follows the normal path to DONE.
- Disabled: no counter is present, timeout_o is tied 0, and WAIT_EVT waits indefinitely.

Decomposition:
- Shared package redmule_pkg:
  - register offset constants: TRIGGER 0x00, ACQUIRE 0x04, SOFT_CLEAR 0x14, REGFILE base 0x40;
  - the dispatcher state enum typedef.
- One natural sub-module, redmule_periph_master_port: holds req/add/data stable until gnt and filters read responses by ID.

Test Plan:
- Single job, gnt=1 every cycle, 1-cycle read latency, ACQUIRE returns 0x0000_0003 → 12 writes to 0x40..0x6C, then a trigger write to 0x00. evt_i after 50 cycles gives job_done_o one pulse with job_id_o=3.
- ACQUIRE returns 0xFFFF_FFFF twice, then 0x1 → three reads spaced by 4 idle cycles; programming starts after the third read.
- Random gnt stall of 0-5 cycles per request → addr/data stay stable while req=1 and gnt=0; write order and values match the descriptor.
- Read response with r_id=5 followed by r_id=0 → the first is ignored and the acquire completes on the second.
- clear_i asserted during PROG with gnt withheld 3 cycles → the current write completes, then IDLE; no trigger write and no job_done_o.
- With REDMULE_DISPATCH_TIMEOUT_EN and TimeoutCycles=16, no evt_i → timeout_o pulses, a write to 0x14 is issued, then IDLE with job_done_o=0.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared definitions for the RedMulE job dispatcher: control-slave register
// offsets, dispatcher state encoding and the internal bus command record.
package redmule_pkg;

  localparam logic [31:0] REG_TRIGGER    = 32'h0000_0000;
  localparam logic [31:0] REG_ACQUIRE    = 32'h0000_0004;
  localparam logic [31:0] REG_SOFT_CLEAR = 32'h0000_0014;
  localparam logic [31:0] REG_REGFILE    = 32'h0000_0040;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACQ,
    ST_ACQ_RSP,
    ST_BACKOFF,
    ST_PROG,
    ST_TRIG,
    ST_WAIT_EVT,
    ST_DONE,
    ST_TMO_CLR
  } disp_state_e;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
  } periph_cmd_t;

endpackage

// File: rtl/redmule_job_dispatcher_if.sv
// HWPE peripheral control bus between the dispatcher (master) and the
// accelerator control slave.
interface redmule_job_dispatcher_if #(
  parameter int unsigned IdWidth = 8
) ();
  logic               req;
  logic               gnt;
  logic [31:0]        add;
  logic               wen;
  logic [3:0]         be;
  logic [31:0]        data;
  logic [IdWidth-1:0] id;
  logic               r_valid;
  logic [31:0]        r_data;
  logic [IdWidth-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/redmule_periph_master_port.sv
// Bus initiator front end: freezes the request once raised until it is
// granted, and only passes read responses tagged with ID 0.
module redmule_periph_master_port
  import redmule_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  periph_cmd_t                     cmd_i,
  output logic                            gnt_o,
  output logic                            rsp_valid_o,
  output logic [31:0]                     rsp_data_o,
  redmule_job_dispatcher_if.master        periph
);

  logic        pend_q;
  periph_cmd_t hold_q;
  periph_cmd_t cur;

  // While stalled, the captured command is replayed regardless of upstream.
  assign cur = pend_q ? hold_q : cmd_i;

  assign periph.req  = cur.req;
  assign periph.add  = cur.add;
  assign periph.wen  = cur.wen;
  assign periph.data = cur.data;
  assign periph.be   = 4'hF;
  assign periph.id   = '0;

  assign gnt_o       = cur.req & periph.gnt;
  assign rsp_valid_o = periph.r_valid & (periph.r_id == '0);
  assign rsp_data_o  = periph.r_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      hold_q <= '0;
    end else if (cur.req && !periph.gnt) begin
      pend_q <= 1'b1;
      hold_q <= cur;
    end else begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/redmule_job_dispatcher.sv
// Offloads one RedMulE job: acquire a context, program the register file,
// trigger, and wait for the completion event. Optional event watchdog is
// enabled by defining REDMULE_DISPATCH_TIMEOUT_EN.
module redmule_job_dispatcher
  import redmule_pkg::*;
#(
  parameter logic [31:0] BaseAddr      = 32'h0000_0000,
  parameter int unsigned NumRegs       = 12,
  parameter int unsigned IdWidth       = 8,
  parameter int unsigned BackoffCycles = 4,
  parameter int unsigned TimeoutCycles = 65536
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [NumRegs*32-1:0]    job_regs_i,
  output logic                     job_done_o,
  output logic [IdWidth-1:0]       job_id_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  input  logic                     evt_i,
  redmule_job_dispatcher_if.master periph
);

  localparam int unsigned    IdxW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int unsigned    BoW     = $clog2(BackoffCycles + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);
  localparam logic [BoW-1:0]  LastBo  = BoW'(BackoffCycles - 1);

  disp_state_e                 state_q, state_d;
  logic [NumRegs-1:0][31:0]    regs_q;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [BoW-1:0]              bo_cnt_q, bo_d;
  logic [IdWidth-1:0]          job_id_q;
  logic                        clr_pend_q, clr_any;
  logic                        accept, id_ld, tmo_fire;
  periph_cmd_t                 cmd;
  logic                        gnt, rsp_valid;
  logic [31:0]                 rsp_data;
  logic                        unused_rsp;

  redmule_periph_master_port i_port (
    .clk_i       ( clk_i     ),
    .rst_ni      ( rst_ni    ),
    .cmd_i       ( cmd       ),
    .gnt_o       ( gnt       ),
    .rsp_valid_o ( rsp_valid ),
    .rsp_data_o  ( rsp_data  ),
    .periph      ( periph    )
  );

  assign unused_rsp  = ^rsp_data;
  assign clr_any     = clear_i | clr_pend_q;
  assign job_ready_o = rst_ni & (state_q == ST_IDLE) & ~clear_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign job_id_o    = job_id_q;
  assign timeout_o   = tmo_fire;

`ifdef REDMULE_DISPATCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Held at zero outside WAIT_EVT so every wait starts from a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    tmo_cnt_q <= '0;
    else if (state_q != ST_WAIT_EVT) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TimeoutCycles;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bo_d       = bo_cnt_q;
    cmd        = '0;
    accept     = 1'b0;
    id_ld      = 1'b0;
    tmo_fire   = 1'b0;
    job_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!clear_i && job_valid_i) begin
          accept  = 1'b1;
          state_d = ST_ACQ;
        end
      end
      ST_ACQ: begin
        cmd.req = 1'b1;
        cmd.wen = 1'b1;
        cmd.add = BaseAddr + REG_ACQUIRE;
        if (gnt) state_d = clr_any ? ST_IDLE : ST_ACQ_RSP;
      end
      ST_ACQ_RSP: begin
        if (rsp_valid) begin
          if (clr_any) begin
            state_d = ST_IDLE;
          end else if (rsp_data[31]) begin
            bo_d    = '0;
            state_d = ST_BACKOFF;
          end else begin
            id_ld   = 1'b1;
            idx_d   = '0;
            state_d = ST_PROG;
          end
        end
      end
      ST_BACKOFF: begin
        if (clear_i)               state_d = ST_IDLE;
        else if (bo_cnt_q == LastBo) state_d = ST_ACQ;
        else                       bo_d = bo_cnt_q + 1'b1;
      end
      ST_PROG: begin
        cmd.req  = 1'b1;
        cmd.add  = BaseAddr + REG_REGFILE + {{(30-IdxW){1'b0}}, idx_q, 2'b00};
        cmd.data = regs_q[idx_q];
        if (gnt) begin
          if (clr_any)               state_d = ST_IDLE;
          else if (idx_q == LastIdx) state_d = ST_TRIG;
          else                       idx_d = idx_q + 1'b1;
        end
      end
      ST_TRIG: begin
        cmd.req = 1'b1;
        cmd.add = BaseAddr + REG_TRIGGER;
        if (gnt) state_d = clr_any ? ST_IDLE : ST_WAIT_EVT;
      end
      ST_WAIT_EVT: begin
        if (clear_i)    state_d = ST_IDLE;
        else if (evt_i) state_d = ST_DONE;
`ifdef REDMULE_DISPATCH_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TimeoutCycles)) begin
          tmo_fire = 1'b1;
          state_d  = ST_TMO_CLR;
        end
`endif
      end
      ST_DONE: begin
        job_done_o = ~clear_i;
        state_d    = ST_IDLE;
      end
`ifdef REDMULE_DISPATCH_TIMEOUT_EN
      ST_TMO_CLR: begin
        cmd.req = 1'b1;
        cmd.add = BaseAddr + REG_SOFT_CLEAR;
        if (gnt) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      regs_q     <= '0;
      idx_q      <= '0;
      bo_cnt_q   <= '0;
      job_id_q   <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bo_cnt_q   <= bo_d;
      // A clear seen mid-transaction is held until the bus lets us leave.
      clr_pend_q <= (state_d == ST_IDLE) ? 1'b0 : (clr_pend_q | clear_i);
      if (id_ld)  job_id_q <= rsp_data[IdWidth-1:0];
      if (accept) regs_q   <= job_regs_i;
    end
  end

endmodule

// File: tb/tb_redmule_job_dispatcher.sv
// Directed bench for redmule_job_dispatcher: table of job scenarios plus
// hand-written clear / timeout sequences against a simple control-slave model.
module tb_redmule_job_dispatcher;
  import redmule_pkg::*;

  localparam int NumRegs = 12;
  localparam int IdW     = 8;
`ifdef REDMULE_DISPATCH_TIMEOUT_EN
  localparam int EvtLong = 10;
`else
  localparam int EvtLong = 50;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0, job_valid_i = 1'b0, evt_i = 1'b0;
  logic [NumRegs*32-1:0] job_regs = '0;
  logic job_ready_o, job_done_o, busy_o, timeout_o;
  logic [IdW-1:0] job_id_o;

  always #5 clk = ~clk;

  redmule_job_dispatcher_if #(.IdWidth(IdW)) bus ();

  redmule_job_dispatcher #(
    .BaseAddr(32'h0), .NumRegs(NumRegs), .IdWidth(IdW),
    .BackoffCycles(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs),
    .job_done_o(job_done_o), .job_id_o(job_id_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .evt_i(evt_i), .periph(bus)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- control-slave model and monitors ----------------
  typedef struct packed { logic [7:0] id; logic [31:0] d; } rsp_t;
  rsp_t        rsp_q[$];
  rsp_t        r_tmp;
  logic [31:0] acq_q[$];
  logic [31:0] wlog_a[$], wlog_d[$];
  int          rd_cyc[$];
  int          stall_max = 0, stall_left = 0;
  bit          stall_fixed = 0, bogus = 0, in_req = 0, prev_pend = 0;
  logic [31:0] prev_add, prev_data;
  logic        prev_wen;
  int          done_cnt = 0, tmo_cnt = 0, acc_cyc = 0, trig_cyc = 0;
  logic [7:0]  done_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_ni) begin
      bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_id = '0;
      in_req = 0; prev_pend = 0;
    end else begin
      if (rsp_q.size() > 0) begin
        r_tmp = rsp_q.pop_front();
        bus.r_valid = 1'b1; bus.r_id = r_tmp.id; bus.r_data = r_tmp.d;
      end else begin
        bus.r_valid = 1'b0; bus.r_id = '0; bus.r_data = '0;
      end
      if (prev_pend) begin
        check("req_held", bus.req, 1);
        check("add_held", bus.add, prev_add);
        check("data_held", bus.data, prev_data);
        check("wen_held", bus.wen, prev_wen);
      end
      bus.gnt = 1'b0;
      if (bus.req) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = stall_fixed ? stall_max : int'($urandom_range(stall_max, 0));
        end
        if (stall_left == 0) begin
          bus.gnt = 1'b1;
          in_req = 0;
          if (bus.wen) begin
            rd_cyc.push_back(cyc);
            if (bogus) begin
              r_tmp.id = 8'd5; r_tmp.d = 32'h0000_0009;
              rsp_q.push_back(r_tmp);
            end
            r_tmp.id = 8'd0;
            r_tmp.d = (acq_q.size() > 0) ? acq_q.pop_front() : 32'hFFFF_FFFF;
            rsp_q.push_back(r_tmp);
          end else begin
            wlog_a.push_back(bus.add);
            wlog_d.push_back(bus.data);
            if (bus.add == REG_TRIGGER) trig_cyc = cyc;
          end
        end else begin
          stall_left--;
        end
      end
      prev_pend = bus.req && !bus.gnt;
      prev_add = bus.add; prev_data = bus.data; prev_wen = bus.wen;
      if (job_done_o) begin done_cnt++; done_id = job_id_o; end
      if (timeout_o) tmo_cnt++;
      if (job_valid_i && job_ready_o) acc_cyc = cyc;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_desc(input int k);
    for (int i = 0; i < NumRegs; i++)
      job_regs[i*32 +: 32] = {8'(k), 8'(i), 16'hBEEF ^ 16'(i * 37)};
  endtask

  task automatic start_job(input logic [31:0] acq);
    acq_q.push_back(acq);
    check("ready_before_job", job_ready_o, 1);
    job_valid_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_trigger(input int w0, output bit seen);
    seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      tick();
      seen = (wlog_a.size() > w0) && (wlog_a[$] == REG_TRIGGER);
    end
    check("trigger_seen", seen, 1);
  endtask

  typedef struct {
    int n_busy; logic [31:0] acq; int stall_max; bit bogus; int evt_delay;
    logic [7:0] exp_id; int exp_reads;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int w0, r0, d0, t0;
    bit seen;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, t0;
    bit seen;
    vecs[0] = '{0, 32'h0000_0003, 0, 0, EvtLong, 8'h03, 1};
    vecs[1] = '{2, 32'h0000_0001, 0, 0, 5,       8'h01, 3};
    vecs[2] = '{0, 32'h0000_00A7, 5, 0, 3,       8'hA7, 1};
    vecs[3] = '{0, 32'h0000_0002, 0, 1, 1,       8'h02, 1};
    vecs[4] = '{1, 32'h7FFF_FF5C, 3, 1, 2,       8'h5C, 2};

    // reset state
    #12;
    check("rst_req", bus.req, 0);
    check("rst_be", bus.be, 4'hF);
    check("rst_add", bus.add, 0);
    check("rst_data", bus.data, 0);
    check("rst_id", bus.id, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", job_ready_o, 0);
    check("rst_done", job_done_o, 0);
    check("rst_jobid", job_id_o, 0);
    check("rst_timeout", timeout_o, 0);
    #11 rst_ni = 1'b1;
    tick();
    check("ready_after_rst", job_ready_o, 1);

    // table-driven jobs
    for (int k = 0; k < 5; k++) begin
      w0 = wlog_a.size(); r0 = rd_cyc.size(); d0 = done_cnt;
      stall_max = vecs[k].stall_max; stall_fixed = 0; bogus = vecs[k].bogus;
      repeat (vecs[k].n_busy) acq_q.push_back(32'hFFFF_FFFF);
      load_desc(k);
      start_job(vecs[k].acq);
      wait_trigger(w0, seen);
      tick(vecs[k].evt_delay);
      evt_i = 1'b1; tick(); evt_i = 1'b0;
      for (int t = 0; t < 20 && done_cnt == d0; t++) tick();
      tick(2);
      check("done_pulses", done_cnt - d0, 1);
      check("busy_after_done", busy_o, 0);
      check("job_id", done_id, vecs[k].exp_id);
      check("reads", rd_cyc.size() - r0, vecs[k].exp_reads);
      check("writes", wlog_a.size() - w0, NumRegs + 1);
      for (int i = 0; i < NumRegs; i++) begin
        check($sformatf("v%0d_wadd%0d", k, i), wlog_a[w0+i], 32'h40 + 32'(4*i));
        check($sformatf("v%0d_wdat%0d", k, i), wlog_d[w0+i], job_regs[i*32 +: 32]);
      end
      check("trig_add", wlog_a[w0+NumRegs], 32'h0);
      check("trig_data", wlog_d[w0+NumRegs], 32'h0);
      // busy reply -> 1 response cycle + 4 backoff cycles -> next ACQ
      if (k == 1) check("acq_spacing", rd_cyc[r0+1] - rd_cyc[r0], 6);
      // acceptance cycle through trigger grant: 2 + 1 + 12 + 1
      if (k == 0) check("trig_latency", trig_cyc - acc_cyc + 1, 16);
    end
    bogus = 0; stall_max = 0;

    // clear during PROG with the in-flight write stalled 3 cycles
    w0 = wlog_a.size(); d0 = done_cnt;
    load_desc(7);
    start_job(32'h0000_0004);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      seen = (wlog_a.size() - w0) >= 4;
    end
    check("prog_started", seen, 1);
    stall_fixed = 1; stall_max = 3;
    tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_busy_while_stalled", busy_o, 1);
    check("clr_req_while_stalled", bus.req, 1);
    tick(8);
    stall_fixed = 0; stall_max = 0;
    check("clr_idle", busy_o, 0);
    check("clr_writes", wlog_a.size() - w0, 5);
    check("clr_last_add", wlog_a[$], 32'h50);
    check("clr_last_data", wlog_d[$], job_regs[4*32 +: 32]);
    check("clr_no_done", done_cnt - d0, 0);

    // clear and valid together in IDLE, then a stray evt in IDLE
    r0 = rd_cyc.size(); d0 = done_cnt;
    job_valid_i = 1'b1; clear_i = 1'b1;
    #1 check("clr_valid_ready", job_ready_o, 0);
    tick(); job_valid_i = 1'b0; clear_i = 1'b0;
    tick(3);
    check("clr_valid_busy", busy_o, 0);
    check("clr_valid_reads", rd_cyc.size() - r0, 0);
    evt_i = 1'b1; tick(); evt_i = 1'b0; tick(2);
    check("idle_evt_ignored", done_cnt - d0, 0);

    // clear while waiting for the event
    w0 = wlog_a.size(); d0 = done_cnt;
    start_job(32'h0000_0006);
    wait_trigger(w0, seen);
    tick(2);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("wait_clr_idle", busy_o, 0);
    evt_i = 1'b1; tick(); evt_i = 1'b0; tick(2);
    check("wait_clr_no_done", done_cnt - d0, 0);

`ifdef REDMULE_DISPATCH_TIMEOUT_EN
    // watchdog expiry with no event
    w0 = wlog_a.size(); d0 = done_cnt; t0 = tmo_cnt;
    start_job(32'h0000_0008);
    wait_trigger(w0, seen);
    seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      seen = tmo_cnt > t0;
    end
    check("tmo_seen", seen, 1);
    tick(4);
    check("tmo_pulses", tmo_cnt - t0, 1);
    check("tmo_clr_add", wlog_a[$], 32'h14);
    check("tmo_clr_data", wlog_d[$], 32'h0);
    check("tmo_writes", wlog_a.size() - w0, NumRegs + 2);
    check("tmo_idle", busy_o, 0);
    check("tmo_no_done", done_cnt - d0, 0);
`else
    check("no_timeout_pulses", tmo_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
